// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes, dmem wait states, plus debug counters and timeout flag.
module hazard_ctrl #(
   parameter int LU_STALL_CYCLES = 1,
   parameter int MEM_TIMEOUT     = 64,
   parameter int CNT_W           = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_bubble,
   output logic             ex_mem_stall,
   output logic             ex_mem_bubble,
   output logic             mem_wb_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_error
);

   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

   localparam logic [1:0] LU_INIT = 2'(LU_STALL_CYCLES - 1);
   localparam logic [7:0] TO      = 8'(MEM_TIMEOUT);

   // Control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
   // id_ex_bubble, ex_mem_stall, ex_mem_bubble, mem_wb_bubble
   localparam logic [7:0] CTRL_FLUSH = 8'b0010_1010;
   localparam logic [7:0] CTRL_WAIT  = 8'b1101_0101;
   localparam logic [7:0] CTRL_LU    = 8'b1100_1000;

   state_t     state, state_next, saved, saved_next, base;
   logic [1:0] lu_cnt, lu_cnt_next;
   logic [7:0] wcnt, wcnt_next;
   logic [7:0] ctrl;
   logic       lu_hit, mw;

   assign lu_hit = ex_memread && (ex_rt != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
   assign mw     = mem_access && !dmem_ready;

   always_comb begin
      ctrl        = 8'b0;
      state_next  = state;
      saved_next  = saved;
      lu_cnt_next = lu_cnt;
      wcnt_next   = wcnt;
      // Once the wait ends, behave as the state the wait interrupted
      base        = (state == MEM_WAIT) ? saved : state;
      if (mem_branch_taken) begin
         ctrl        = CTRL_FLUSH;
         state_next  = RUN;
         lu_cnt_next = 2'd0;
         wcnt_next   = 8'd0;
      end else if (mw) begin
         ctrl       = CTRL_WAIT;
         state_next = MEM_WAIT;
         if (state != MEM_WAIT) begin
            saved_next = state;
            wcnt_next  = 8'd1;
         end else if (wcnt != 8'hFF) begin
            wcnt_next = wcnt + 8'd1;
         end
      end else begin
         wcnt_next  = 8'd0;
         state_next = RUN;
         if (base == LU_STALL) begin
            ctrl        = CTRL_LU;
            lu_cnt_next = lu_cnt - 2'd1;
            if (lu_cnt > 2'd1) state_next = LU_STALL;
         end else if (lu_hit) begin
            ctrl = CTRL_LU;
            if (LU_STALL_CYCLES > 1) begin
               state_next  = LU_STALL;
               lu_cnt_next = LU_INIT;
            end
         end
      end
   end

   // Reset forces the controls low immediately, even mid-stall
   assign {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_bubble, ex_mem_stall, ex_mem_bubble, mem_wb_bubble} = reset ? 8'b0 : ctrl;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         saved       <= RUN;
         lu_cnt      <= 2'd0;
         wcnt        <= 8'd0;
         mem_error   <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state  <= state_next;
         saved  <= saved_next;
         lu_cnt <= lu_cnt_next;
         wcnt   <= wcnt_next;
         if (wcnt_next >= TO) mem_error <= 1'b1;
         if (pc_stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
         if (if_id_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LU_STALL_CYCLES=1 and 2, MEM_TIMEOUT=8)
// driven by shared directed vectors, checked against a cycle model and literals.
module tb_hazard_ctrl;

   localparam int TO = 8;
   localparam logic [7:0] Z  = 8'b0000_0000;
   localparam logic [7:0] FL = 8'b0010_1010;
   localparam logic [7:0] MW = 8'b1101_0101;
   localparam logic [7:0] LU = 8'b1100_1000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rs = 0, id_uses_rt = 0, ex_memread = 0;
   logic       mem_branch_taken = 0, mem_access = 0, dmem_ready = 0;

   logic [1:0]  pc_stall, if_id_stall, if_id_flush, id_ex_stall;
   logic [1:0]  id_ex_bubble, ex_mem_stall, ex_mem_bubble, mem_wb_bubble, mem_error;
   logic [15:0] stall_count [2];
   logic [15:0] flush_count [2];

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      hazard_ctrl #(.LU_STALL_CYCLES(gi + 1), .MEM_TIMEOUT(TO), .CNT_W(16)) u_dut (
         .clock(clock), .reset(reset),
         .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
         .ex_memread(ex_memread), .ex_rt(ex_rt),
         .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
         .pc_stall(pc_stall[gi]), .if_id_stall(if_id_stall[gi]), .if_id_flush(if_id_flush[gi]),
         .id_ex_stall(id_ex_stall[gi]), .id_ex_bubble(id_ex_bubble[gi]),
         .ex_mem_stall(ex_mem_stall[gi]), .ex_mem_bubble(ex_mem_bubble[gi]),
         .mem_wb_bubble(mem_wb_bubble[gi]),
         .stall_count(stall_count[gi]), .flush_count(flush_count[gi]),
         .mem_error(mem_error[gi])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] get_ctrl(input int k);
      return {pc_stall[k], if_id_stall[k], if_id_flush[k], id_ex_stall[k],
              id_ex_bubble[k], ex_mem_stall[k], ex_mem_bubble[k], mem_wb_bubble[k]};
   endfunction

   // Model: pending load-use cycles, current wait length, counters
   int   lu_rem [2]   = '{0, 0};
   int   wait_len [2] = '{0, 0};
   int   stalls [2]   = '{0, 0};
   int   flushes [2]  = '{0, 0};
   logic err_m [2]    = '{1'b0, 1'b0};

   function automatic logic hit_now();
      return ex_memread && ex_rt != 0 &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
   endfunction

   function automatic logic [7:0] exp_ctrl(input int k);
      if (reset) return Z;
      if (mem_branch_taken) return FL;
      if (mem_access && !dmem_ready) return MW;
      if (lu_rem[k] > 0 || hit_now()) return LU;
      return Z;
   endfunction

   always @(posedge clock or posedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            lu_rem[k] = 0; wait_len[k] = 0; stalls[k] = 0; flushes[k] = 0; err_m[k] = 0;
         end else if (mem_branch_taken) begin
            lu_rem[k] = 0; wait_len[k] = 0;
            if (flushes[k] < 65535) flushes[k]++;
         end else if (mem_access && !dmem_ready) begin
            if (stalls[k] < 65535) stalls[k]++;
            if (wait_len[k] < 255) wait_len[k]++;
            if (wait_len[k] >= TO) err_m[k] = 1;
         end else begin
            wait_len[k] = 0;
            if (lu_rem[k] > 0) begin
               lu_rem[k]--;
               if (stalls[k] < 65535) stalls[k]++;
            end else if (hit_now()) begin
               lu_rem[k] = k;  // instance k stalls k+1 cycles per hazard
               if (stalls[k] < 65535) stalls[k]++;
            end
         end
      end
   end

   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         check($sformatf("model_ctrl[%0d]", k), 32'(get_ctrl(k)), 32'(exp_ctrl(k)));
         check($sformatf("model_stall_count[%0d]", k), 32'(stall_count[k]), reset ? 0 : stalls[k]);
         check($sformatf("model_flush_count[%0d]", k), 32'(flush_count[k]), reset ? 0 : flushes[k]);
         check($sformatf("model_mem_error[%0d]", k), 32'(mem_error[k]), reset ? 0 : 32'(err_m[k]));
      end
   end

   task automatic vec(input string name, input logic br, ma, rdy, mr,
                      input logic [4:0] ert, rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic [7:0] ea, eb);
      mem_branch_taken = br; mem_access = ma; dmem_ready = rdy; ex_memread = mr;
      ex_rt = ert; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
      #1;
      $display("[TB] %-10s ctrl_a=%08b ctrl_b=%08b", name, get_ctrl(0), get_ctrl(1));
      check({name, "_a"}, 32'(get_ctrl(0)), 32'(ea));
      check({name, "_b"}, 32'(get_ctrl(1)), 32'(eb));
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic [7:0] ea, eb);
      vec("idle", 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, ea, eb);
   endtask

   task automatic cnts(input string name, input int sa, sb, fa, fb, input logic ea, eb);
      check({name, "_stall_a"}, 32'(stall_count[0]), sa);
      check({name, "_stall_b"}, 32'(stall_count[1]), sb);
      check({name, "_flush_a"}, 32'(flush_count[0]), fa);
      check({name, "_flush_b"}, 32'(flush_count[1]), fb);
      check({name, "_err_a"}, 32'(mem_error[0]), 32'(ea));
      check({name, "_err_b"}, 32'(mem_error[1]), 32'(eb));
   endtask

   initial begin
      // Reset held with a memory wait pending
      for (int i = 0; i < 3; i++) vec("rst_mw", 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, Z, Z);
      cnts("rst", 0, 0, 0, 0, 0, 0);
      reset = 0;
      idle(Z, Z);
      idle(Z, Z);
      cnts("post_rst", 0, 0, 0, 0, 0, 0);

      // Load-use through RS, RS==RT==0 exemption, RT path, unused-operand case
      vec("lu_rs", 0, 0, 0, 1, 5'd8, 5'd8, 1, 5'd0, 0, LU, LU);
      idle(Z, LU);
      cnts("lu_rs", 1, 2, 0, 0, 0, 0);
      idle(Z, Z);
      vec("lu_rt0", 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, Z, Z);
      vec("lu_rt", 0, 0, 0, 1, 5'd5, 5'd0, 0, 5'd5, 1, LU, LU);
      idle(Z, LU);
      vec("lu_nouse", 0, 0, 0, 1, 5'd5, 5'd5, 0, 5'd0, 0, Z, Z);
      cnts("lu_rt", 2, 4, 0, 0, 0, 0);

      // Branch in MEM overtakes the pending second load-use cycle
      vec("lu_br", 0, 0, 0, 1, 5'd8, 5'd8, 1, 5'd0, 0, LU, LU);
      vec("br", 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, FL, FL);
      idle(Z, Z);
      cnts("br", 3, 5, 1, 1, 0, 0);

      // Four wait cycles then ready
      for (int i = 0; i < 4; i++) vec("mw4", 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MW, MW);
      vec("ready", 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, Z, Z);
      cnts("mw4", 7, 9, 1, 1, 0, 0);

      // Timeout: error rises as the 8th wait cycle completes, stays sticky
      for (int i = 1; i <= 10; i++) begin
         vec("mw10", 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MW, MW);
         check($sformatf("tmo_err_a_%0d", i), 32'(mem_error[0]), (i >= TO) ? 1 : 0);
         check($sformatf("tmo_err_b_%0d", i), 32'(mem_error[1]), (i >= TO) ? 1 : 0);
      end
      vec("ready", 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, Z, Z);
      cnts("tmo", 17, 19, 1, 1, 1, 1);

      // Wait interrupting a load-use stall resumes the remaining stall cycle
      vec("lu_mw", 0, 0, 0, 1, 5'd8, 5'd8, 1, 5'd0, 0, LU, LU);
      vec("mw", 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MW, MW);
      vec("mw", 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MW, MW);
      vec("ready", 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, Z, LU);
      idle(Z, Z);
      cnts("lu_mw", 20, 23, 1, 1, 1, 1);

      // All three hazards at once: flush wins
      vec("all3", 1, 1, 0, 1, 5'd8, 5'd8, 1, 5'd0, 0, FL, FL);
      idle(Z, Z);
      cnts("all3", 20, 23, 2, 2, 1, 1);

      // Reset in the middle of a wait
      vec("mw", 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, MW, MW);
      reset = 1;
      vec("mw_rst", 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, Z, Z);
      cnts("mid_rst", 0, 0, 0, 0, 0, 0);
      reset = 0;
      idle(Z, Z);
      vec("lu_again", 0, 0, 0, 1, 5'd3, 5'd0, 0, 5'd3, 1, LU, LU);
      idle(Z, LU);
      idle(Z, Z);
      cnts("final", 1, 2, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
